// File: rtl/id_stage_pipe_if.sv
// ID/EX pipeline boundary bundle: registered decode results handed from the
// decode stage (master) to the execute stage (slave).
interface id_stage_pipe_if #(
    parameter int BIT_NUMBER   = 32,
    parameter int REG_NUM_BITS = 4
);
    logic                    id_valid;
    logic                    wb_en;
    logic                    mem_r_en;
    logic                    mem_w_en;
    logic                    b;
    logic                    s;
    logic                    imm;
    logic [3:0]              exe_cmd;
    logic [REG_NUM_BITS-1:0] dest;
    logic [REG_NUM_BITS-1:0] src1;
    logic [REG_NUM_BITS-1:0] src2;
    logic [11:0]             shift_operand;
    logic [23:0]             signed_imm_24;
    logic [BIT_NUMBER-1:0]   val_rn;
    logic [BIT_NUMBER-1:0]   val_rm;
    logic [BIT_NUMBER-1:0]   pc_out;

    modport master (
        output id_valid, wb_en, mem_r_en, mem_w_en, b, s, imm, exe_cmd,
               dest, src1, src2, shift_operand, signed_imm_24,
               val_rn, val_rm, pc_out
    );

    modport slave (
        input  id_valid, wb_en, mem_r_en, mem_w_en, b, s, imm, exe_cmd,
               dest, src1, src2, shift_operand, signed_imm_24,
               val_rn, val_rm, pc_out
    );
endinterface

// File: rtl/id_stage_pipe.sv
// ARM decode stage: register file with write-first bypass, control decode,
// condition check, RAW hazard detection and a registered ID/EX boundary.
module id_stage_pipe #(
    parameter int BIT_NUMBER   = 32,
    parameter int REG_NUM_BITS = 4,
    parameter bit FORWARD_EN   = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BIT_NUMBER-1:0]   instruction,
    input  logic                    instr_valid,
    input  logic [BIT_NUMBER-1:0]   pc_in,
    input  logic [3:0]              sr,
    input  logic                    flush,
    input  logic                    wb_wb_en,
    input  logic [REG_NUM_BITS-1:0] dest_wb,
    input  logic [BIT_NUMBER-1:0]   result_wb,
    input  logic                    exe_wb_en,
    input  logic                    exe_mem_r_en,
    input  logic [REG_NUM_BITS-1:0] exe_dest,
    input  logic                    mem_wb_en,
    input  logic [REG_NUM_BITS-1:0] mem_dest,
    output logic                    stall,
    id_stage_pipe_if.master         id_ex
);
    localparam int RF_DEPTH = 2 ** REG_NUM_BITS;

    logic [3:0]              cond;
    logic [1:0]              mode;
    logic                    i_bit;
    logic [3:0]              opcode;
    logic                    s_bit;
    logic [REG_NUM_BITS-1:0] rn_idx, rd_idx, rm_idx, src2_idx;

    assign cond   = instruction[31:28];
    assign mode   = instruction[27:26];
    assign i_bit  = instruction[25];
    assign opcode = instruction[24:21];
    assign s_bit  = instruction[20];
    assign rn_idx = REG_NUM_BITS'(instruction[19:16]);
    assign rd_idx = REG_NUM_BITS'(instruction[15:12]);
    assign rm_idx = REG_NUM_BITS'(instruction[3:0]);

    // ---------------- register file ----------------
    logic [BIT_NUMBER-1:0] rf_reg [RF_DEPTH];
    logic [RF_DEPTH-1:0]   wr_sel;

    for (genvar gi = 0; gi < RF_DEPTH; gi++) begin : g_wr_sel
        assign wr_sel[gi] = wb_wb_en && (dest_wb == REG_NUM_BITS'(gi));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < RF_DEPTH; i++) rf_reg[i] <= '0;
        end else begin
            for (int i = 0; i < RF_DEPTH; i++)
                if (wr_sel[i]) rf_reg[i] <= result_wb;
        end
    end

    logic [BIT_NUMBER-1:0] rn_val, rm_val;
    // Write-first: a value being written back this cycle is seen by the read.
    assign rn_val = (wb_wb_en && dest_wb == rn_idx)   ? result_wb : rf_reg[rn_idx];
    assign rm_val = (wb_wb_en && dest_wb == src2_idx) ? result_wb : rf_reg[src2_idx];

    // ---------------- control decode ----------------
    logic       dec_wb_en, dec_mem_r_en, dec_mem_w_en, dec_b, dec_s;
    logic [3:0] dec_exe_cmd;

    always_comb begin
        dec_wb_en    = 1'b0;
        dec_mem_r_en = 1'b0;
        dec_mem_w_en = 1'b0;
        dec_b        = 1'b0;
        dec_s        = 1'b0;
        dec_exe_cmd  = 4'b0000;
        case (mode)
            2'b00: begin
                dec_wb_en = 1'b1;
                dec_s     = s_bit;
                case (opcode)
                    4'b1101: dec_exe_cmd = 4'b0001;
                    4'b1111: dec_exe_cmd = 4'b1001;
                    4'b0100: dec_exe_cmd = 4'b0010;
                    4'b0101: dec_exe_cmd = 4'b0011;
                    4'b0010: dec_exe_cmd = 4'b0100;
                    4'b0110: dec_exe_cmd = 4'b0101;
                    4'b0000: dec_exe_cmd = 4'b0110;
                    4'b1100: dec_exe_cmd = 4'b0111;
                    4'b0001: dec_exe_cmd = 4'b1000;
                    4'b1010: begin dec_exe_cmd = 4'b0100; dec_wb_en = 1'b0; dec_s = 1'b1; end
                    4'b1000: begin dec_exe_cmd = 4'b0110; dec_wb_en = 1'b0; dec_s = 1'b1; end
                    default: begin dec_wb_en = 1'b0; dec_s = 1'b0; end
                endcase
            end
            2'b01: begin
                dec_exe_cmd = 4'b0010;
                if (s_bit) begin
                    dec_mem_r_en = 1'b1;
                    dec_wb_en    = 1'b1;
                end else begin
                    dec_mem_w_en = 1'b1;
                end
            end
            2'b10:   dec_b = 1'b1;
            default: ;
        endcase
    end

    assign src2_idx = dec_mem_w_en ? rd_idx : rm_idx;

    // ---------------- condition check ----------------
    logic flag_n, flag_z, flag_c, flag_v, cond_ok;
    assign {flag_n, flag_z, flag_c, flag_v} = sr;

    always_comb begin
        case (cond)
            4'b0000: cond_ok = flag_z;
            4'b0001: cond_ok = ~flag_z;
            4'b0010: cond_ok = flag_c;
            4'b0011: cond_ok = ~flag_c;
            4'b0100: cond_ok = flag_n;
            4'b0101: cond_ok = ~flag_n;
            4'b0110: cond_ok = flag_v;
            4'b0111: cond_ok = ~flag_v;
            4'b1000: cond_ok = flag_c & ~flag_z;
            4'b1001: cond_ok = ~flag_c | flag_z;
            4'b1010: cond_ok = (flag_n == flag_v);
            4'b1011: cond_ok = (flag_n != flag_v);
            4'b1100: cond_ok = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_ok = flag_z | (flag_n != flag_v);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end

    // ---------------- hazard detection ----------------
    logic rn_used, two_src, match_exe, match_mem, hazard;
    assign rn_used = ~(mode == 2'b10) &
                     ~((mode == 2'b00) && (opcode == 4'b1101 || opcode == 4'b1111));
    assign two_src = ~i_bit | dec_mem_w_en;

    assign match_exe = (rn_used && rn_idx == exe_dest) || (two_src && src2_idx == exe_dest);
    assign match_mem = (rn_used && rn_idx == mem_dest) || (two_src && src2_idx == mem_dest);

    // With forwarding only a load still in EXE cannot be bypassed in time.
    if (FORWARD_EN) begin : g_fwd
        assign hazard = instr_valid & exe_wb_en & exe_mem_r_en & match_exe;
    end else begin : g_nofwd
        assign hazard = instr_valid & ((exe_wb_en & match_exe) | (mem_wb_en & match_mem));
    end

    assign stall = hazard & ~flush;

    // ---------------- ID/EX register ----------------
    logic issue;
    assign issue = ~flush & ~hazard & cond_ok & instr_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_ex.id_valid      <= 1'b0;
            id_ex.wb_en         <= 1'b0;
            id_ex.mem_r_en      <= 1'b0;
            id_ex.mem_w_en      <= 1'b0;
            id_ex.b             <= 1'b0;
            id_ex.s             <= 1'b0;
            id_ex.imm           <= 1'b0;
            id_ex.exe_cmd       <= '0;
            id_ex.dest          <= '0;
            id_ex.src1          <= '0;
            id_ex.src2          <= '0;
            id_ex.shift_operand <= '0;
            id_ex.signed_imm_24 <= '0;
            id_ex.val_rn        <= '0;
            id_ex.val_rm        <= '0;
            id_ex.pc_out        <= '0;
        end else begin
            id_ex.id_valid      <= issue;
            id_ex.wb_en         <= issue & dec_wb_en;
            id_ex.mem_r_en      <= issue & dec_mem_r_en;
            id_ex.mem_w_en      <= issue & dec_mem_w_en;
            id_ex.b             <= issue & dec_b;
            id_ex.s             <= issue & dec_s;
            id_ex.imm           <= i_bit;
            id_ex.exe_cmd       <= dec_exe_cmd;
            id_ex.dest          <= rd_idx;
            id_ex.src1          <= rn_idx;
            id_ex.src2          <= src2_idx;
            id_ex.shift_operand <= instruction[11:0];
            id_ex.signed_imm_24 <= instruction[23:0];
            id_ex.val_rn        <= rn_val;
            id_ex.val_rm        <= rm_val;
            id_ex.pc_out        <= pc_in;
        end
    end
endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: one instance without forwarding (u0) and
// one with forwarding (u1) share every input.
module tb_id_stage_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] instruction = '0;
    logic        instr_valid = 1'b0;
    logic [31:0] pc_in = '0;
    logic [3:0]  sr = '0;
    logic        flush = 1'b0;
    logic        wb_wb_en = 1'b0;
    logic [3:0]  dest_wb = '0;
    logic [31:0] result_wb = '0;
    logic        exe_wb_en = 1'b0;
    logic        exe_mem_r_en = 1'b0;
    logic [3:0]  exe_dest = '0;
    logic        mem_wb_en = 1'b0;
    logic [3:0]  mem_dest = '0;
    logic        stall0, stall1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_stage_pipe_if #(.BIT_NUMBER(32), .REG_NUM_BITS(4)) ex0 ();
    id_stage_pipe_if #(.BIT_NUMBER(32), .REG_NUM_BITS(4)) ex1 ();

    id_stage_pipe #(.BIT_NUMBER(32), .REG_NUM_BITS(4), .FORWARD_EN(1'b0)) u0 (
        .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
        .pc_in(pc_in), .sr(sr), .flush(flush), .wb_wb_en(wb_wb_en), .dest_wb(dest_wb),
        .result_wb(result_wb), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .exe_dest(exe_dest), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
        .stall(stall0), .id_ex(ex0)
    );

    id_stage_pipe #(.BIT_NUMBER(32), .REG_NUM_BITS(4), .FORWARD_EN(1'b1)) u1 (
        .clk(clk), .rst(rst), .instruction(instruction), .instr_valid(instr_valid),
        .pc_in(pc_in), .sr(sr), .flush(flush), .wb_wb_en(wb_wb_en), .dest_wb(dest_wb),
        .result_wb(result_wb), .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en),
        .exe_dest(exe_dest), .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
        .stall(stall1), .id_ex(ex1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_side();
        flush = 0; wb_wb_en = 0; exe_wb_en = 0; exe_mem_r_en = 0; mem_wb_en = 0;
        exe_dest = 4'hF; mem_dest = 4'hF; dest_wb = 0; result_wb = 0;
    endtask

    task automatic test_reset();
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (ex0.id_valid !== 1'b0) begin n_err++; $display("FAIL reset_id_valid got %b want 0", ex0.id_valid); end
        n_cmp++; if (ex0.exe_cmd !== 4'h0) begin n_err++; $display("FAIL reset_exe_cmd got %h want 0", ex0.exe_cmd); end
        n_cmp++; if (ex0.pc_out !== 32'h0 || ex0.val_rn !== 32'h0) begin n_err++; $display("FAIL reset_data got pc %h rn %h want 0", ex0.pc_out, ex0.val_rn); end
        n_cmp++; if (stall0 !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", stall0); end
        $display("reset: id_valid=%b stall=%b", ex0.id_valid, stall0);
        rst = 1;
    endtask

    task automatic test_add();
        clear_side();
        instruction = 32'hE0821003; instr_valid = 1; sr = 4'h0; pc_in = 32'h104;
        step();
        n_cmp++; if (ex0.id_valid !== 1'b1) begin n_err++; $display("FAIL add_id_valid got %b want 1", ex0.id_valid); end
        n_cmp++; if (ex0.wb_en !== 1'b1 || ex0.s !== 1'b0 || ex0.mem_r_en !== 1'b0) begin n_err++; $display("FAIL add_ctrl got wb %b s %b mr %b want 1 0 0", ex0.wb_en, ex0.s, ex0.mem_r_en); end
        n_cmp++; if (ex0.exe_cmd !== 4'b0010) begin n_err++; $display("FAIL add_exe_cmd got %b want 0010", ex0.exe_cmd); end
        n_cmp++; if ({ex0.dest, ex0.src1, ex0.src2} !== 12'h123) begin n_err++; $display("FAIL add_regs got %h want 123", {ex0.dest, ex0.src1, ex0.src2}); end
        n_cmp++; if (ex0.val_rn !== 32'h0 || ex0.val_rm !== 32'h0) begin n_err++; $display("FAIL add_vals got %h %h want 0 0", ex0.val_rn, ex0.val_rm); end
        n_cmp++; if (ex0.pc_out !== 32'h104) begin n_err++; $display("FAIL add_pc got %h want 104", ex0.pc_out); end
        $display("add: id_valid=%b exe_cmd=%b pc=%h", ex0.id_valid, ex0.exe_cmd, ex0.pc_out);
    endtask

    task automatic test_bypass();
        clear_side();
        instruction = 32'hE0821003; instr_valid = 1;
        wb_wb_en = 1; dest_wb = 4'd2; result_wb = 32'h55;
        step();
        n_cmp++; if (ex0.val_rn !== 32'h55) begin n_err++; $display("FAIL bypass_rn got %h want 55", ex0.val_rn); end
        dest_wb = 4'd3; result_wb = 32'hAA;
        step();
        n_cmp++; if (ex0.val_rm !== 32'hAA) begin n_err++; $display("FAIL bypass_rm got %h want aa", ex0.val_rm); end
        wb_wb_en = 0; result_wb = 32'hDEAD;
        step();
        n_cmp++; if (ex0.val_rn !== 32'h55 || ex0.val_rm !== 32'hAA) begin n_err++; $display("FAIL rf_hold got %h %h want 55 aa", ex0.val_rn, ex0.val_rm); end
        $display("bypass: val_rn=%h val_rm=%h", ex0.val_rn, ex0.val_rm);
    endtask

    task automatic test_hazard();
        clear_side();
        instruction = 32'hE0821003; instr_valid = 1;
        exe_wb_en = 1; exe_dest = 4'd2;
        #1;
        n_cmp++; if (stall0 !== 1'b1) begin n_err++; $display("FAIL haz_exe_stall0 got %b want 1", stall0); end
        n_cmp++; if (stall1 !== 1'b0) begin n_err++; $display("FAIL haz_fwd_stall1 got %b want 0", stall1); end
        step();
        n_cmp++; if (ex0.id_valid !== 1'b0 || ex0.wb_en !== 1'b0) begin n_err++; $display("FAIL haz_bubble0 got v %b wb %b want 0 0", ex0.id_valid, ex0.wb_en); end
        n_cmp++; if (ex1.id_valid !== 1'b1) begin n_err++; $display("FAIL haz_fwd_issue got %b want 1", ex1.id_valid); end
        exe_mem_r_en = 1;
        #1;
        n_cmp++; if (stall1 !== 1'b1) begin n_err++; $display("FAIL haz_loaduse_stall1 got %b want 1", stall1); end
        step();
        n_cmp++; if (ex1.id_valid !== 1'b0) begin n_err++; $display("FAIL haz_loaduse_bubble got %b want 0", ex1.id_valid); end
        clear_side(); mem_wb_en = 1; mem_dest = 4'd3;
        #1;
        n_cmp++; if (stall0 !== 1'b1 || stall1 !== 1'b0) begin n_err++; $display("FAIL haz_mem got %b %b want 1 0", stall0, stall1); end
        mem_dest = 4'd5;
        #1;
        n_cmp++; if (stall0 !== 1'b0) begin n_err++; $display("FAIL haz_nomatch got %b want 0", stall0); end
        mem_dest = 4'd3; instr_valid = 0;
        #1;
        n_cmp++; if (stall0 !== 1'b0) begin n_err++; $display("FAIL haz_invalid got %b want 0", stall0); end
        step();
        n_cmp++; if (ex0.id_valid !== 1'b0) begin n_err++; $display("FAIL invalid_bubble got %b want 0", ex0.id_valid); end
        $display("hazard: stall0=%b stall1=%b", stall0, stall1);
    endtask

    task automatic test_mem_ops();
        clear_side();
        instruction = 32'hE5854000; instr_valid = 1;
        step();
        n_cmp++; if (ex0.mem_w_en !== 1'b1 || ex0.wb_en !== 1'b0 || ex0.mem_r_en !== 1'b0) begin n_err++; $display("FAIL str_ctrl got mw %b wb %b mr %b want 1 0 0", ex0.mem_w_en, ex0.wb_en, ex0.mem_r_en); end
        n_cmp++; if (ex0.src2 !== 4'd4 || ex0.src1 !== 4'd5 || ex0.exe_cmd !== 4'b0010) begin n_err++; $display("FAIL str_fields got src2 %h src1 %h cmd %b want 4 5 0010", ex0.src2, ex0.src1, ex0.exe_cmd); end
        exe_wb_en = 1; exe_dest = 4'd4;
        #1;
        n_cmp++; if (stall0 !== 1'b1) begin n_err++; $display("FAIL str_rd_hazard got %b want 1", stall0); end
        clear_side();
        instruction = 32'hE5954000;
        step();
        n_cmp++; if (ex0.mem_r_en !== 1'b1 || ex0.wb_en !== 1'b1 || ex0.mem_w_en !== 1'b0) begin n_err++; $display("FAIL ldr_ctrl got mr %b wb %b mw %b want 1 1 0", ex0.mem_r_en, ex0.wb_en, ex0.mem_w_en); end
        $display("mem: ldr mem_r_en=%b wb_en=%b", ex0.mem_r_en, ex0.wb_en);
    endtask

    task automatic test_decode_misc();
        clear_side();
        instruction = 32'hE1520003; instr_valid = 1;
        step();
        n_cmp++; if (ex0.exe_cmd !== 4'b0100 || ex0.wb_en !== 1'b0 || ex0.s !== 1'b1) begin n_err++; $display("FAIL cmp_ctrl got cmd %b wb %b s %b want 0100 0 1", ex0.exe_cmd, ex0.wb_en, ex0.s); end
        instruction = 32'hE3A01005; exe_wb_en = 1; exe_dest = 4'd0;
        #1;
        n_cmp++; if (stall0 !== 1'b0) begin n_err++; $display("FAIL mov_no_rn got %b want 0", stall0); end
        step();
        n_cmp++; if (ex0.exe_cmd !== 4'b0001 || ex0.imm !== 1'b1 || ex0.id_valid !== 1'b1) begin n_err++; $display("FAIL mov_ctrl got cmd %b imm %b v %b want 0001 1 1", ex0.exe_cmd, ex0.imm, ex0.id_valid); end
        clear_side();
        instruction = 32'hEA000010;
        step();
        n_cmp++; if (ex0.b !== 1'b1 || ex0.wb_en !== 1'b0 || ex0.signed_imm_24 !== 24'h000010) begin n_err++; $display("FAIL branch got b %b wb %b imm24 %h want 1 0 000010", ex0.b, ex0.wb_en, ex0.signed_imm_24); end
        $display("decode: branch b=%b imm24=%h", ex0.b, ex0.signed_imm_24);
    endtask

    task automatic test_cond();
        clear_side();
        instruction = 32'h00821003; instr_valid = 1; sr = 4'b0000;
        step();
        n_cmp++; if (ex0.id_valid !== 1'b0 || ex0.wb_en !== 1'b0) begin n_err++; $display("FAIL cond_eq_fail got v %b wb %b want 0 0", ex0.id_valid, ex0.wb_en); end
        sr = 4'b0100;
        step();
        n_cmp++; if (ex0.id_valid !== 1'b1 || ex0.wb_en !== 1'b1) begin n_err++; $display("FAIL cond_eq_pass got v %b wb %b want 1 1", ex0.id_valid, ex0.wb_en); end
        instruction = 32'hC0821003; sr = 4'b1001;
        step();
        n_cmp++; if (ex0.id_valid !== 1'b1) begin n_err++; $display("FAIL cond_gt got %b want 1", ex0.id_valid); end
        instruction = 32'hF0821003;
        step();
        n_cmp++; if (ex0.id_valid !== 1'b0) begin n_err++; $display("FAIL cond_nv got %b want 0", ex0.id_valid); end
        sr = 4'b0000;
        $display("cond: nv id_valid=%b", ex0.id_valid);
    endtask

    task automatic test_flush();
        clear_side();
        instruction = 32'hE0821003; instr_valid = 1;
        exe_wb_en = 1; exe_mem_r_en = 1; exe_dest = 4'd2; flush = 1;
        #1;
        n_cmp++; if (stall0 !== 1'b0 || stall1 !== 1'b0) begin n_err++; $display("FAIL flush_stall got %b %b want 0 0", stall0, stall1); end
        step();
        n_cmp++; if (ex0.id_valid !== 1'b0 || ex1.id_valid !== 1'b0) begin n_err++; $display("FAIL flush_bubble got %b %b want 0 0", ex0.id_valid, ex1.id_valid); end
        clear_side();
        step();
        n_cmp++; if (ex0.id_valid !== 1'b1) begin n_err++; $display("FAIL after_flush got %b want 1", ex0.id_valid); end
        $display("flush: stall0=%b id_valid=%b", stall0, ex0.id_valid);
    endtask

    task automatic test_async_reset();
        clear_side();
        instruction = 32'hE0821003; instr_valid = 1; pc_in = 32'h200;
        step();
        #2;
        rst = 0;
        #1;
        n_cmp++; if (ex0.id_valid !== 1'b0 || ex0.pc_out !== 32'h0 || ex0.val_rn !== 32'h0) begin n_err++; $display("FAIL async_rst got v %b pc %h rn %h want 0 0 0", ex0.id_valid, ex0.pc_out, ex0.val_rn); end
        exe_wb_en = 1; exe_dest = 4'd2;
        #1;
        n_cmp++; if (stall0 !== 1'b1) begin n_err++; $display("FAIL rst_stall_comb got %b want 1", stall0); end
        step();
        clear_side();
        rst = 1;
        step();
        n_cmp++; if (ex0.id_valid !== 1'b1 || ex0.pc_out !== 32'h200) begin n_err++; $display("FAIL rst_release got v %b pc %h want 1 200", ex0.id_valid, ex0.pc_out); end
        n_cmp++; if (ex0.val_rn !== 32'h0 || ex0.val_rm !== 32'h0) begin n_err++; $display("FAIL rf_cleared got %h %h want 0 0", ex0.val_rn, ex0.val_rm); end
        $display("async_reset: id_valid=%b val_rn=%h", ex0.id_valid, ex0.val_rn);
    endtask

    initial begin
        test_reset();
        test_add();
        test_bypass();
        test_hazard();
        test_mem_ops();
        test_decode_misc();
        test_cond();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/id_stage_pipe.md
Name: id_stage_pipe

Overview:
- Parametrised decode stage for the ARM pipeline; successor of the combinational decode block.
- Contains the register file (write-first bypass), control decode, condition check and hazard detection with optional forwarding mode.
- Holds a registered ID/EX pipeline boundary with stall, flush and valid tracking.
- Sits between the IF/ID register and the EXE stage; all outputs to EXE are registered.

Parameters:
BIT_NUMBER, 32, datapath and register width
REG_NUM_BITS, 4, register index width; file depth = 2**REG_NUM_BITS
FORWARD_EN, 0, 0: stall on any RAW match; 1: stall only on load-use in EXE

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
instruction  in  BIT_NUMBER  instruction from IF/ID
instr_valid  in  1  instruction slot holds a real instruction
pc_in  in  BIT_NUMBER  PC+4 of instruction
sr  in  4  status {N,Z,C,V}
flush  in  1  branch taken in EXE; kill current decode
wb_wb_en, dest_wb, result_wb  in  1/REG_NUM_BITS/BIT_NUMBER  write-back port
exe_wb_en, exe_mem_r_en, exe_dest  in  1/1/REG_NUM_BITS  instruction currently in EXE
mem_wb_en, mem_dest  in  1/REG_NUM_BITS  instruction currently in MEM
stall  out  1  combinational; freeze PC and IF/ID
id_valid  out  1  registered valid to EXE
wb_en, mem_r_en, mem_w_en, b, s, imm  out  1 each  registered control
exe_cmd  out  4  registered ALU command
dest, src1, src2  out  REG_NUM_BITS  registered rd, rn, second source
shift_operand  out  12  registered instr[11:0]
signed_imm_24  out  24  registered instr[23:0]
val_rn, val_rm  out  BIT_NUMBER  registered operand values
pc_out  out  BIT_NUMBER  registered pc_in

Behaviour:
- Fields: cond [31:28], mode [27:26], I [25], opcode [24:21], S [20], rn [19:16], rd [15:12], rm [3:0].
- src2 = rd when decoded mem_w_en (STR), otherwise rm. two_src = ~I | mem_w_en.
- rn is used unless the instruction is a branch or MOV/MVN.
- Decode, mode 00 (opcode -> exe_cmd, wb_en = 1, s = S):
  - MOV 1101 -> 0001
  - MVN 1111 -> 1001
  - ADD 0100 -> 0010
  - ADC 0101 -> 0011
  - SUB 0010 -> 0100
  - SBC 0110 -> 0101
  - AND 0000 -> 0110
  - ORR 1100 -> 0111
  - EOR 0001 -> 1000
  - CMP 1010 -> 0100, wb_en = 0, s = 1
  - TST 1000 -> 0110, wb_en = 0, s = 1
  - Any other opcode: all controls 0.
- Decode, mode 01: exe_cmd = 0010. S = 1 is LDR (mem_r_en = 1, wb_en = 1); S = 0 is STR (mem_w_en = 1); s = 0.
- Decode, mode 10: b = 1, all other controls 0.
- Decode, mode 11: all controls 0.
- Condition check: standard ARM EQ..AL on sr. Code 1111 fails.
- Hazard:
  - match(x) = (src1 == x and rn used) or (src2 == x and two_src).
  - FORWARD_EN = 0: hazard = instr_valid & ((exe_wb_en & match(exe_dest)) | (mem_wb_en & match(mem_dest))).
  - FORWARD_EN = 1: hazard = instr_valid & exe_wb_en & exe_mem_r_en & match(exe_dest).
- stall = hazard & ~flush.
- ID/EX register, on rising clk:
  - flush = 1: load bubble.
  - Else hazard, condition fail, or ~instr_valid: load bubble.
  - Else load decoded values with id_valid = 1.
  - Bubble: id_valid, wb_en, mem_r_en, mem_w_en, b, s = 0. Data fields are don't-care but are driven with decoded values.
- Latency: exactly 1 cycle from instruction to registered outputs.
- Register file, 2**REG_NUM_BITS entries:
  - Written on rising clk when wb_wb_en.
  - Reads are combinational with write-first bypass: if wb_wb_en and dest_wb equals the read index, return result_wb in the same cycle.
- Reset (rst = 0), asynchronous:
  - All ID/EX outputs 0, including id_valid, exe_cmd, val_rn, val_rm, pc_out.
  - All register file entries 0.
  - stall still evaluates combinationally from its inputs.
- Reset release mid-stream: the first rising edge after release captures the current instruction normally.

Test Plan:
- Reset, then ADD r1,r2,r3 (0xE0821003), valid, sr = 0 -> next cycle: id_valid = 1, wb_en = 1, exe_cmd = 0010, dest = 1, src1 = 2, src2 = 3, val_rn = val_rm = 0.
- Write-back r2 = 0x55 (wb_wb_en = 1, dest_wb = 2) in the same cycle as decoding ADD r1,r2,r3 -> val_rn = 0x55 next cycle (bypass).
- FORWARD_EN = 0, exe_wb_en = 1, exe_dest = 2 while decoding ADD r1,r2,r3 -> stall = 1 and a bubble is loaded.
  - With FORWARD_EN = 1 and exe_mem_r_en = 0 -> stall = 0, id_valid = 1.
  - With exe_mem_r_en = 1 -> stall = 1.
- STR r4,[r5] (0xE5854000) -> mem_w_en = 1, src2 = 4, exe_cmd = 0010, wb_en = 0.
- ADDEQ (0x00821003) with sr = 0000 -> bubble, id_valid = 0; with sr = 0100 -> issued.
- flush = 1 together with a hazard -> stall = 0, bubble loaded.
- Assert rst low mid-stream -> outputs clear immediately without waiting for a clock edge.
